// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO push port among NUM_REQ
// byte streams, with message lock, burst cap and stall timeout.
// Ports: clk, rst_n (sync, active-low); req_valid/req_data/req_last in,
//   req_ready out (per requester); tx_valid/tx_data out, tx_ready in
//   (FIFO push); gnt one-hot grant, busy; err_timeout pulse, err_src.
// Option: define UART_ARB_PRIO0_EN to make requester 0 win every
//   IDLE decision without moving the round-robin pointer.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 255,
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1),
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [IW-1:0]        err_src
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] src_q, src_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          err_q, err_d;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic [7:0]    sel_data;
  logic          xfer;
  logic          rel;

  // Downward scan so the lowest offset from rr_q wins.
  always_comb begin
    pick = rr_q;
    idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
`ifdef UART_ARB_PRIO0_EN
    if (req_valid[0]) pick = '0;
`endif
  end

  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_q == IW'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  assign busy        = (state_q == GRANT);
  assign gnt         = busy ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << g_q)
                            : '0;
  assign tx_valid    = busy & req_valid[g_q];
  assign tx_data     = tx_valid ? sel_data : 8'h00;
  assign req_ready   = gnt & {NUM_REQ{tx_ready}};
  assign xfer        = tx_valid & tx_ready;
  assign err_timeout = err_q;
  assign err_src     = src_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    err_d   = 1'b0;
    src_d   = src_q;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = GRANT;
          g_d     = pick;
          beat_d  = '0;
          idle_d  = '0;
        end
      end
      GRANT: begin
        // Backpressure (valid, not ready) touches neither counter.
        unique case (1'b1)
          xfer: begin
            beat_d = beat_q + 1'b1;
            idle_d = '0;
            rel    = req_last[g_q] |
                     (beat_q == BW'(MAX_BURST - 1));
          end
          !tx_valid: begin
            if (idle_q != TW'(TIMEOUT_CYC))
              idle_d = idle_q + 1'b1;
            if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
              rel   = 1'b1;
              err_d = 1'b1;
              src_d = g_q;
            end
          end
          default: ;
        endcase
        if (rel) begin
          state_d = IDLE;
          rr_d    = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
`ifdef UART_ARB_PRIO0_EN
          if (g_q == '0) rr_d = rr_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// every cycle checked against a behavioural arbitration model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 255;
`ifdef UART_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic [N-1:0] gnt;
  logic         busy;
  logic         err_timeout;
  logic [1:0]   err_src;

  uart_tx_arbiter #(
    .NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .gnt(gnt), .busy(busy),
    .err_timeout(err_timeout), .err_src(err_src)
  );

  always #5 clk = ~clk;

  // pending bytes per requester: {last, data}
  logic [8:0] q[N][$];
  logic [7:0] out_q[$];
  int         out_t[$];

  int tests = 0, fails = 0;
  int own = -1, beats = 0, idle = 0, rr = 0;
  int m_err = 0, m_src = 0;
  int cyc_n = 0, n_err = 0, err_t = 0, last_src = 0;
  int total = 0, t0 = 0;
  bit always_v = 1'b1;
  int rdy_mode = 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d,
                      input logic l);
    q[i].push_back({l, d});
    total++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic v;
      v = (q[i].size() > 0) &&
          (always_v || $urandom_range(0, 3) != 0);
      req_valid[i] = v;
      req_data[8*i +: 8] = v ? q[i][0][7:0] : 8'($urandom);
      req_last[i] = v ? q[i][0][8] : 1'($urandom);
    end
    case (rdy_mode)
      0: tx_ready = ($urandom_range(0, 3) != 0);
      1: tx_ready = 1'b1;
      default: tx_ready = 1'b0;
    endcase
  endtask

  // Reference: one owner at a time; it keeps the port until its
  // message ends, it has sent MB bytes, or it stays silent TO cycles.
  task automatic model_next();
    if (!rst_n) begin
      own = -1; rr = 0; m_err = 0; m_src = 0;
      beats = 0; idle = 0;
      return;
    end
    m_err = 0;
    if (own < 0) begin
      int p;
      p = -1;
      for (int k = 0; k < N; k++) begin
        if (p < 0 && req_valid[(rr + k) % N]) p = (rr + k) % N;
      end
      if (PRIO && req_valid[0]) p = 0;
      if (p >= 0) begin
        own = p; beats = 0; idle = 0;
      end
    end else begin
      bit done;
      done = 1'b0;
      if (req_valid[own] && tx_ready) begin
        logic [8:0] b;
        b = q[own].pop_front();
        beats++;
        idle = 0;
        done = b[8] || (beats == MB);
      end else if (!req_valid[own]) begin
        idle++;
        if (idle == TO) begin
          done = 1'b1; m_err = 1; m_src = own;
        end
      end
      if (done) begin
        if (!(PRIO && own == 0)) rr = (own + 1) % N;
        own = -1;
      end
    end
  endtask

  task automatic cyc();
    logic [N-1:0] eg;
    logic         etv;
    logic [7:0]   etd;
    @(negedge clk);
    eg  = (own >= 0) ? N'(1 << own) : '0;
    etv = (own >= 0) ? req_valid[own] : 1'b0;
    etd = etv ? req_data[8*own +: 8] : 8'h00;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(own >= 0));
    chk("tx_valid", 32'(tx_valid), 32'(etv));
    chk("tx_data", 32'(tx_data), 32'(etd));
    chk("req_ready", 32'(req_ready),
        32'(tx_ready ? eg : '0));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("err_src", 32'(err_src), 32'(m_src));
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      out_q.push_back(tx_data);
      out_t.push_back(cyc_n);
    end
    if (err_timeout === 1'b1) begin
      n_err++;
      err_t = cyc_n;
      last_src = int'(err_src);
    end
    model_next();
    @(posedge clk);
    #1;
    cyc_n++;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    req_valid = '0;
    run(n);
    rst_n = 1'b1;
    out_q.delete();
    out_t.delete();
    n_err = 0;
    total = 0;
  endtask

  task automatic start();
    drive();
    t0 = cyc_n;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    // single requester, three-byte message
    push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
    start();
    run(6);
    chk("t1_cnt", 32'(out_q.size()), 3);
    chk("t1_b0", 32'(out_q[0]), 32'h41);
    chk("t1_b2", 32'(out_q[2]), 32'h43);
    chk("t1_lat", 32'(out_t[0] - t0), 1);
    chk("t1_span", 32'(out_t[2] - out_t[0]), 2);

    // contention, single-byte messages
    do_reset(2);
    for (int i = 0; i < N; i++) push(i, 8'(8'hA0 + i), 1);
    start();
    run(12);
    for (int k = 0; k < N; k++)
      chk("t2_order", 32'(out_q[k]), 32'(8'hA0 + k));
    chk("t2_rate", 32'(out_t[3] - out_t[0]), 6);
    push(0, 8'hB0, 1); push(2, 8'hB2, 1);
    start();
    run(6);
    chk("t2_wrap0", 32'(out_q[4]), 32'hB0);
    chk("t2_wrap1", 32'(out_q[5]), 32'hB2);

    // burst cap
    do_reset(2);
    for (int k = 0; k < 20; k++) push(2, 8'(8'h10 + k), k == 19);
    push(3, 8'hEE, 1);
    start();
    run(40);
    chk("t3_cnt", 32'(out_q.size()), 21);
    chk("t3_b16", 32'(out_q[15]), 32'h1F);
    chk("t3_r3", 32'(out_q[16]), 32'hEE);
    chk("t3_b17", 32'(out_q[17]), 32'h20);
    chk("t3_b20", 32'(out_q[20]), 32'h23);

    // long backpressure
    do_reset(2);
    for (int k = 0; k < 5; k++) push(1, 8'(8'h50 + k), k == 4);
    start();
    run(3);
    rdy_mode = 2;
    run(300);
    rdy_mode = 1;
    run(8);
    chk("t4_noerr", 32'(n_err), 0);
    chk("t4_cnt", 32'(out_q.size()), 5);
    chk("t4_b4", 32'(out_q[4]), 32'h54);

    // timeout, then reset during a grant
    do_reset(2);
    push(1, 8'h61, 0); push(1, 8'h62, 0);
    start();
    run(270);
    chk("t5_pulses", 32'(n_err), 1);
    chk("t5_src", 32'(last_src), 1);
    chk("t5_when", 32'(err_t - out_t[1]), 256);
    for (int k = 0; k < 10; k++) push(2, 8'(8'h70 + k), k == 9);
    start();
    run(3);
    do_reset(1);
    run(1);
    push(1, 8'hC1, 1); push(3, 8'hC3, 1);
    start();
    run(6);
    chk("t5_rr0_a", 32'(out_q[0]), 32'hC1);
    chk("t5_rr0_b", 32'(out_q[1]), 32'hC3);

    // requester-0 priority option
    do_reset(2);
    push(1, 8'hD1, 1);
    start();
    run(4);
    out_q.delete();
    push(0, 8'hD0, 1); push(2, 8'hD2, 1);
    start();
    run(6);
    chk("t6_first", 32'(out_q[0]), PRIO ? 32'hD0 : 32'hD2);
    chk("t6_second", 32'(out_q[1]), PRIO ? 32'hD2 : 32'hD0);

    // random traffic
    do_reset(2);
    always_v = 1'b0;
    rdy_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        int r, len;
        r   = $urandom_range(0, N - 1);
        len = $urandom_range(1, 20);
        if (q[r].size() < 40)
          for (int k = 0; k < len; k++)
            push(r, 8'($urandom), k == len - 1);
      end
      cyc();
    end
    always_v = 1'b1;
    rdy_mode = 1;
    run(600);
    chk("t7_drain", 32'(out_q.size()), 32'(total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
